// File: rtl/chan_pkt_responder.sv
// Channel-side packet responder: buffers acquisition words into packets and streams one
// packet (header, pad, data, trailer) or the end-of-fill word per transfer-manager request.
//
// state | meaning
// IDLE  | wait for a pending hit; choose packet or end-of-fill
// LOAD  | pop descriptor, stage header
// HDR0  | header word on the link
// HDR1  | pad word on the link
// DATA  | packet words, one per cycle
// TRL   | xor trailer on the link
// EOF   | all-ones end-of-fill word on the link
module chan_pkt_responder #(
  parameter logic [2:0] CHAN_ID = 3'd0,
  parameter int         DATA_AW = 10,
  parameter int         PKT_AW  = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [63:0]       wr_data,
  input  logic              wr_last,
  input  logic              fill_done,
  output logic              wr_full,
  output logic              overflow,
  input  logic              chan_data_req,
  input  logic [2:0]        chan_select,
  output logic [63:0]       channel_rx,
  output logic              channel_rx_en,
  output logic [PKT_AW:0]   pkt_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HDR0 = 3'd2;
  localparam logic [2:0] S_HDR1 = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_TRL  = 3'd5;
  localparam logic [2:0] S_EOF  = 3'd6;

  localparam int DDEPTH = 1 << DATA_AW;
  localparam int PDEPTH = 1 << PKT_AW;
  localparam logic [DATA_AW:0] D_FULL = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [PKT_AW:0]  P_FULL = {1'b1, {PKT_AW{1'b0}}};

  logic [63:0] dmem [DDEPTH];
  logic [47:0] pmem [PDEPTH];

  logic [DATA_AW-1:0] dwp_q, drp_q;
  logic [DATA_AW:0]   dcnt_q, dcnt_d;
  logic [PKT_AW-1:0]  pwp_q, prp_q;
  logic [PKT_AW:0]    pcnt_q, pcnt_d;
  logic [15:0]        len_acc_q, len_nxt;
  logic [31:0]        xor_acc_q, xor_nxt;
  logic               fill_q, ovf_q, full_q, full_d;
  logic               pend_q, pend_d;
  logic [2:0]         state_q, state_d;
  logic [15:0]        seq_q, seq_d;
  logic [15:0]        rem_q, rem_d;
  logic [31:0]        cur_xor_q, cur_xor_d;
  logic [63:0]        rx_q, rx_d;
  logic               en_q, en_d;
  logic               wr_acc, close, hit, pend, d_pop, p_pop, fill_clr;
  logic [47:0]        desc_head;

  assign wr_acc    = wr_en & ~full_q;
  assign len_nxt   = len_acc_q + 16'd1;
  assign xor_nxt   = xor_acc_q ^ wr_data[63:32] ^ wr_data[31:0];
  // A packet that reaches the 16-bit length limit is closed even without wr_last.
  assign close     = wr_acc & (wr_last | (len_acc_q == 16'hFFFE));
  assign hit       = chan_data_req & (chan_select == CHAN_ID);
  assign pend      = pend_q | hit;
  assign desc_head = pmem[prp_q];

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    rx_d      = 64'h0;
    en_d      = 1'b0;
    d_pop     = 1'b0;
    p_pop     = 1'b0;
    fill_clr  = 1'b0;
    rem_d     = rem_q;
    cur_xor_d = cur_xor_q;
    seq_d     = seq_q;
    case (state_q)
      S_IDLE: begin
        pend_d = pend;
        if (pend && (pcnt_q != '0)) begin
          state_d = S_LOAD;
          pend_d  = 1'b0;
        end else if (pend && fill_q) begin
          state_d = S_EOF;
          pend_d  = 1'b0;
          rx_d    = '1;
          en_d    = 1'b1;
        end
      end
      S_LOAD: begin
        p_pop     = 1'b1;
        rem_d     = desc_head[47:32];
        cur_xor_d = desc_head[31:0];
        rx_d      = {4'hA, 1'b0, CHAN_ID, 8'h00, seq_q, 16'h0000, desc_head[47:32]};
        en_d      = 1'b1;
        state_d   = S_HDR0;
      end
      S_HDR0: begin
        en_d    = 1'b1;
        state_d = S_HDR1;
      end
      S_HDR1: begin
        rx_d    = dmem[drp_q];
        en_d    = 1'b1;
        d_pop   = 1'b1;
        rem_d   = rem_q - 16'd1;
        state_d = S_DATA;
      end
      S_DATA: begin
        en_d = 1'b1;
        if (rem_q == 16'd0) begin
          rx_d    = {32'h0, cur_xor_q};
          state_d = S_TRL;
        end else begin
          rx_d  = dmem[drp_q];
          d_pop = 1'b1;
          rem_d = rem_q - 16'd1;
        end
      end
      S_TRL: begin
        seq_d   = seq_q + 16'd1;
        state_d = S_IDLE;
      end
      S_EOF: begin
        fill_clr = 1'b1;
        seq_d    = 16'd0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dcnt_d = dcnt_q + (DATA_AW+1)'(wr_acc) - (DATA_AW+1)'(d_pop);
  assign pcnt_d = pcnt_q + (PKT_AW+1)'(close) - (PKT_AW+1)'(p_pop);
  assign full_d = (dcnt_d == D_FULL) | (pcnt_d == P_FULL);

  always_ff @(posedge clk_in) begin
    if (wr_acc) dmem[dwp_q] <= wr_data;
    if (close)  pmem[pwp_q] <= {len_nxt, xor_nxt};
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      dwp_q     <= '0;
      drp_q     <= '0;
      dcnt_q    <= '0;
      pwp_q     <= '0;
      prp_q     <= '0;
      pcnt_q    <= '0;
      len_acc_q <= '0;
      xor_acc_q <= '0;
      fill_q    <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      pend_q    <= 1'b0;
      state_q   <= S_IDLE;
      seq_q     <= '0;
      rem_q     <= '0;
      cur_xor_q <= '0;
      rx_q      <= '0;
      en_q      <= 1'b0;
    end else begin
      if (wr_acc) dwp_q <= dwp_q + DATA_AW'(1);
      if (d_pop)  drp_q <= drp_q + DATA_AW'(1);
      if (close)  pwp_q <= pwp_q + PKT_AW'(1);
      if (p_pop)  prp_q <= prp_q + PKT_AW'(1);
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
      full_q <= full_d;
      if (close) begin
        len_acc_q <= '0;
        xor_acc_q <= '0;
      end else if (wr_acc) begin
        len_acc_q <= len_nxt;
        xor_acc_q <= xor_nxt;
      end
      if (wr_en & full_q) ovf_q <= 1'b1;
      // A fill_done arriving while EOF is being sent opens the next fill's latch.
      if (fill_done)     fill_q <= 1'b1;
      else if (fill_clr) fill_q <= 1'b0;
      pend_q    <= pend_d;
      state_q   <= state_d;
      seq_q     <= seq_d;
      rem_q     <= rem_d;
      cur_xor_q <= cur_xor_d;
      rx_q      <= rx_d;
      en_q      <= en_d;
    end
  end

  assign wr_full       = full_q;
  assign overflow      = ovf_q;
  assign channel_rx    = rx_q;
  assign channel_rx_en = en_q;
  assign pkt_count     = pcnt_q;

endmodule

// File: tb/tb_chan_pkt_responder.sv
// Bench for chan_pkt_responder: transaction-level model of buffered packets and the
// expected link stream, compared word by word on every cycle the link is enabled.
module tb_chan_pkt_responder;

  localparam logic [2:0] CID = 3'd2;
  localparam int DATA_AW = 10;
  localparam int PKT_AW  = 4;
  localparam int DDEPTH  = 1 << DATA_AW;
  localparam int PDEPTH  = 1 << PKT_AW;

  logic              clk_in = 1'b0;
  logic              rst;
  logic              wr_en, wr_last, fill_done, chan_data_req;
  logic [63:0]       wr_data;
  logic [2:0]        chan_select;
  logic              wr_full, overflow, channel_rx_en;
  logic [63:0]       channel_rx;
  logic [PKT_AW:0]   pkt_count;

  chan_pkt_responder #(.CHAN_ID(CID), .DATA_AW(DATA_AW), .PKT_AW(PKT_AW)) dut (
    .clk_in(clk_in), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .fill_done(fill_done), .wr_full(wr_full), .overflow(overflow),
    .chan_data_req(chan_data_req), .chan_select(chan_select),
    .channel_rx(channel_rx), .channel_rx_en(channel_rx_en), .pkt_count(pkt_count)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // reference model: buffered words/packets, fill latch, sequence, expected stream
  logic [63:0] m_data [$];
  logic [15:0] m_plen [$];
  logic [31:0] m_pxor [$];
  logic [15:0] m_len, m_seq;
  logic [31:0] m_xor;
  bit          m_fill, m_pend;
  logic [63:0] exp_q [$];
  bit          exp_last [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_data.delete(); m_plen.delete(); m_pxor.delete();
    exp_q.delete(); exp_last.delete();
    m_len = 0; m_xor = 0; m_seq = 0; m_fill = 0; m_pend = 0;
  endfunction

  function automatic void m_serve();
    logic [15:0] l;
    if (!m_pend) return;
    if (m_plen.size() > 0) begin
      l = m_plen.pop_front();
      exp_q.push_back({4'hA, 1'b0, CID, 8'h00, m_seq, 16'h0000, l}); exp_last.push_back(0);
      exp_q.push_back(64'h0); exp_last.push_back(0);
      for (int i = 0; i < int'(l); i++) begin
        exp_q.push_back(m_data.pop_front()); exp_last.push_back(0);
      end
      exp_q.push_back({32'h0, m_pxor.pop_front()}); exp_last.push_back(1);
      m_seq = m_seq + 16'd1;
      m_pend = 0;
    end else if (m_fill) begin
      exp_q.push_back('1); exp_last.push_back(1);
      m_fill = 0; m_seq = 0; m_pend = 0;
    end
  endfunction

  // link monitor: every enabled cycle is compared against the model stream
  bit          prev_en = 0, prev_last = 0;
  int          first_en_cyc = 0, bidx = 0, en_count = 0;
  logic [63:0] bbuf [8];
  always @(negedge clk_in) begin
    if (rst) begin
      prev_en = 0; prev_last = 0;
    end else begin
      if (channel_rx_en) begin
        en_count++;
        if (!prev_en) begin first_en_cyc = cyc; bidx = 0; end
        else chk("gap_between_bursts", {63'h0, prev_last}, 64'h0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word got=%h exp=none", channel_rx);
          prev_last = 1;
        end else begin
          chk("stream_word", channel_rx, exp_q.pop_front());
          prev_last = exp_last.pop_front();
        end
        if (bidx < 8) bbuf[bidx] = channel_rx;
        bidx++;
      end else if (prev_en) begin
        chk("burst_complete", {63'h0, prev_last}, 64'h1);
      end
      prev_en = channel_rx_en;
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic wr(input logic [63:0] d, input bit last);
    wr_en = 1; wr_data = d; wr_last = last;
    if (m_data.size() < DDEPTH && m_plen.size() < PDEPTH) begin
      m_data.push_back(d);
      m_len = m_len + 16'd1;
      m_xor = m_xor ^ d[63:32] ^ d[31:0];
      if (last || m_len == 16'hFFFF) begin
        m_plen.push_back(m_len); m_pxor.push_back(m_xor);
        m_len = 0; m_xor = 0;
        m_serve();
      end
    end
    tick();
    wr_en = 0; wr_last = 0;
  endtask

  int hit_cyc = 0;
  task automatic req(input logic [2:0] ch);
    chan_data_req = 1; chan_select = ch;
    if (ch == CID) begin m_pend = 1; m_serve(); end
    hit_cyc = cyc;
    tick();
    chan_data_req = 0;
  endtask

  task automatic fill();
    fill_done = 1; m_fill = 1; m_serve();
    tick();
    fill_done = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || channel_rx_en) && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout got=%0d exp=<3000", n);
    end
    repeat (2) tick();
  endtask

  task automatic summary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int h, wc, ec, n, cnt;
    logic [2:0] ch;
    m_reset();
    rst = 1; wr_en = 0; wr_last = 0; wr_data = 0; fill_done = 0;
    chan_data_req = 0; chan_select = 0;
    repeat (3) tick();
    chk("rst_en", {63'h0, channel_rx_en}, 64'h0);
    chk("rst_rx", channel_rx, 64'h0);
    chk("rst_pkt_count", 64'(pkt_count), 64'h0);
    chk("rst_wr_full", {63'h0, wr_full}, 64'h0);
    chk("rst_overflow", {63'h0, overflow}, 64'h0);
    rst = 0;
    tick();

    // one 3-word packet, literal header/trailer and latency
    wr(64'h1111_2222_3333_4444, 0);
    wr(64'h0000_00FF_0000_0F00, 0);
    wr(64'hDEAD_BEEF_0000_0000, 1);
    chk("t1_pkt_count", 64'(pkt_count), 64'h1);
    req(CID); h = hit_cyc;
    wait_idle();
    chk("t1_latency", 64'(first_en_cyc - h), 64'd2);
    chk("t1_burst_len", 64'(bidx), 64'd6);
    chk("t1_header", bbuf[0], 64'hA200_0000_0000_0003);
    chk("t1_trailer", bbuf[5], 64'h0000_0000_FC8F_D776);
    chk("t1_pkt_count_after", 64'(pkt_count), 64'h0);

    // end-of-fill word
    fill();
    req(CID); h = hit_cyc;
    wait_idle();
    chk("eof_latency", 64'(first_en_cyc - h), 64'd1);
    chk("eof_len", 64'(bidx), 64'd1);
    chk("eof_word", bbuf[0], 64'hFFFF_FFFF_FFFF_FFFF);

    // pending hit on empty buffer; fill latch must be clear
    ec = en_count;
    req(CID);
    repeat (20) tick();
    chk("pend_no_output", 64'(en_count), 64'(ec));
    wr(64'h0123_4567_89AB_CDEF, 0);
    wr(64'h5555_AAAA_5555_AAAA, 0);
    wc = cyc;
    wr(64'hFEDC_BA98_7654_3210, 1);
    wait_idle();
    chk("pend_latency", 64'(first_en_cyc - wc), 64'd3);
    chk("pend_header", bbuf[0], 64'hA200_0000_0000_0003);

    // channel select filtering
    wr(64'hAAAA_0000_BBBB_0000, 0);
    wr(64'hCCCC_0000_DDDD_0000, 1);
    ec = en_count;
    for (int c = 0; c < 8; c++) if (c != int'(CID)) req(3'(c));
    repeat (10) tick();
    chk("wrong_chan_ignored", 64'(en_count), 64'(ec));
    req(CID);
    wait_idle();
    chk("right_chan_len", 64'(bidx), 64'd5);

    // sequence numbering across a fill
    fill(); req(CID); wait_idle();
    wr(64'h1, 1);
    wr(64'h2, 0); wr(64'h3, 1);
    fill();
    req(CID); wait_idle();
    chk("seq_first", 64'(bbuf[0][47:32]), 64'h0);
    req(CID); wait_idle();
    chk("seq_second", 64'(bbuf[0][47:32]), 64'h1);
    req(CID); wait_idle();
    chk("seq_eof", bbuf[0], 64'hFFFF_FFFF_FFFF_FFFF);
    wr(64'h9, 1);
    req(CID); wait_idle();
    chk("seq_restart", bbuf[0], 64'hA200_0000_0000_0001);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(1, 8);
      for (int w = 0; w < n; w++) wr({$urandom, $urandom}, w == n - 1);
      if ($urandom_range(0, 3) == 0) begin
        ch = 3'($urandom_range(0, 7));
        if (ch != CID) req(ch);
      end
      if ($urandom_range(0, 9) == 0) fill();
      if ($urandom_range(0, 2) != 0 || m_plen.size() >= 8) begin
        wait_idle();
        req(CID);
        wait_idle();
        chk("rand_pkt_count", 64'(pkt_count), 64'(m_plen.size()));
        chk("rand_overflow", {63'h0, overflow}, 64'h0);
      end
    end
    wait_idle();
    if (m_pend) begin wr(64'h77, 1); wait_idle(); end
    cnt = 0;
    while ((m_plen.size() > 0 || m_fill) && cnt < 40) begin
      req(CID); wait_idle(); cnt++;
    end
    chk("drain_pkt_count", 64'(pkt_count), 64'h0);

    // overflow, then reset in the middle of a packet
    for (int i = 0; i < DDEPTH; i++) wr(64'(i) * 64'h0001_0003_0005_0007, i == DDEPTH - 1);
    chk("ovf_full", {63'h0, wr_full}, 64'h1);
    chk("ovf_not_yet", {63'h0, overflow}, 64'h0);
    for (int i = 0; i < 5; i++) wr(64'hBAD0_0000_0000_0000 + 64'(i), i == 4);
    chk("ovf_sticky", {63'h0, overflow}, 64'h1);
    chk("ovf_dropped_pkt", 64'(pkt_count), 64'h1);
    req(CID);
    cnt = 0;
    while (!(channel_rx_en && bidx > 10) && cnt < 200) begin tick(); cnt++; end
    chk("ovf_reached_data", 64'(cnt < 200), 64'h1);
    rst = 1;
    m_reset();
    #1;
    chk("rst_mid_en", {63'h0, channel_rx_en}, 64'h0);
    chk("rst_mid_pkt_count", 64'(pkt_count), 64'h0);
    chk("rst_mid_overflow", {63'h0, overflow}, 64'h0);
    chk("rst_mid_full", {63'h0, wr_full}, 64'h0);
    repeat (2) tick();
    rst = 0;
    tick();
    wr(64'h4242_4242_0000_0001, 1);
    req(CID); wait_idle();
    chk("post_rst_header", bbuf[0], 64'hA200_0000_0000_0001);
    chk("post_rst_trailer", bbuf[3], 64'h0000_0000_4242_4243);

    summary();
    $finish;
  end

endmodule
